// File: rtl/pc_unit_pkg.sv
// Shared state encodings and default constants for the fetch PC unit.
package pc_unit_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_t;

    localparam logic [63:0] DEF_RESET_VEC = 64'h0;
    localparam int unsigned DEF_STEP      = 4;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: trap > aligned redirect > misaligned redirect > accept > hold.
module pc_next_sel
    import pc_unit_pkg::*;
#(
    parameter int unsigned XLEN = 64,
    parameter int unsigned STEP = DEF_STEP
) (
    input  logic [XLEN-1:0] pc,
    input  logic            accept,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_epc,
    input  logic [XLEN-1:0] trap_vec,
    output logic [XLEN-1:0] next_pc,
    output logic            epc_load,
    output logic [XLEN-1:0] epc_val,
    output logic            misalign_set
);

    localparam int unsigned AW = $clog2(STEP);

    logic target_aligned;

    assign target_aligned = (redirect_target[AW-1:0] == '0);

    always_comb begin
        next_pc      = pc;
        epc_load     = 1'b0;
        epc_val      = '0;
        misalign_set = 1'b0;
        if (trap_valid) begin
            next_pc  = trap_vec;
            epc_load = 1'b1;
            epc_val  = trap_epc;
        end else if (redirect_valid && target_aligned) begin
            next_pc = redirect_target;
        end else if (redirect_valid) begin
            // Misaligned target becomes a trap that records the bad target.
            next_pc      = trap_vec;
            epc_load     = 1'b1;
            epc_val      = redirect_target;
            misalign_set = 1'b1;
        end else if (accept) begin
            next_pc = pc + XLEN'(STEP);
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch PC register with BOOT/RUN/HALT control, epc capture and accepted-fetch counter.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int unsigned     XLEN      = 64,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
    parameter int unsigned     STEP      = DEF_STEP,
    parameter int unsigned     CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetch_ready,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    input  logic             trap_valid,
    input  logic [XLEN-1:0]  trap_epc,
    input  logic [XLEN-1:0]  trap_vec,
    input  logic             halt,
    output logic [XLEN-1:0]  pc,
    output logic             fetch_valid,
    output logic [XLEN-1:0]  epc,
    output logic             misalign,
    output logic [CNT_W-1:0] fetch_cnt
);

    pc_state_t       state, state_nxt;
    logic            accept;
    logic [XLEN-1:0] next_pc;
    logic            epc_load;
    logic [XLEN-1:0] epc_val;
    logic            misalign_set;

    assign fetch_valid = (state == ST_RUN);
    assign accept      = fetch_valid && fetch_ready;

    pc_next_sel #(
        .XLEN (XLEN),
        .STEP (STEP)
    ) u_sel (
        .pc              (pc),
        .accept          (accept),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_valid      (trap_valid),
        .trap_epc        (trap_epc),
        .trap_vec        (trap_vec),
        .next_pc         (next_pc),
        .epc_load        (epc_load),
        .epc_val         (epc_val),
        .misalign_set    (misalign_set)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_BOOT, ST_RUN, ST_HALT: state_nxt = halt ? ST_HALT : ST_RUN;
            default:                  state_nxt = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_BOOT;
            pc        <= RESET_VEC;
            epc       <= '0;
            misalign  <= 1'b0;
            fetch_cnt <= '0;
        end else begin
            state    <= state_nxt;
            pc       <= next_pc;
            misalign <= misalign_set;
            if (epc_load) begin
                epc <= epc_val;
            end
            if (accept) begin
                fetch_cnt <= fetch_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: driver queues expected post-edge state, monitor checks it.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_ready;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic        trap_valid;
    logic [63:0] trap_epc;
    logic [63:0] trap_vec;
    logic        halt;
    logic [63:0] pc;
    logic        fetch_valid;
    logic [63:0] epc;
    logic        misalign;
    logic [31:0] fetch_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] pc;
        logic        fv;
        logic [63:0] epc;
        logic        mis;
        logic [31:0] cnt;
        string       name;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    pc_unit #(
        .XLEN      (64),
        .RESET_VEC (64'h0),
        .STEP      (4),
        .CNT_W     (32)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .fetch_ready     (fetch_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_valid      (trap_valid),
        .trap_epc        (trap_epc),
        .trap_vec        (trap_vec),
        .halt            (halt),
        .pc              (pc),
        .fetch_valid     (fetch_valid),
        .epc             (epc),
        .misalign        (misalign),
        .fetch_cnt       (fetch_cnt)
    );

    task automatic chk64(input string name, input string fld, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h", name, fld, act, exp);
        end
    endtask

    // Monitor: the outputs after each rising edge are compared with the queued entry.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk64(e.name, "pc",          pc,                 e.pc);
                chk64(e.name, "fetch_valid", {63'd0, fetch_valid}, {63'd0, e.fv});
                chk64(e.name, "epc",         epc,                e.epc);
                chk64(e.name, "misalign",    {63'd0, misalign},  {63'd0, e.mis});
                chk64(e.name, "fetch_cnt",   {32'd0, fetch_cnt}, {32'd0, e.cnt});
            end
        end
    end

    task automatic step(input logic rst, input logic fr, input logic rv, input logic [63:0] tgt,
                        input logic tv, input logic [63:0] tepc, input logic h,
                        input logic [63:0] xpc, input logic xfv, input logic [63:0] xepc,
                        input logic xmis, input logic [31:0] xcnt, input string name);
        exp_t e;
        @(negedge clk);
        reset           = rst;
        fetch_ready     = fr;
        redirect_valid  = rv;
        redirect_target = tgt;
        trap_valid      = tv;
        trap_epc        = tepc;
        halt            = h;
        e.pc = xpc; e.fv = xfv; e.epc = xepc; e.mis = xmis; e.cnt = xcnt; e.name = name;
        sb.push_back(e);
    endtask

    initial begin
        reset = 1'b1; fetch_ready = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        trap_valid = 1'b0; trap_epc = '0; trap_vec = 64'h800; halt = 1'b0;

        //    rst fr  rv  tgt     tv  tepc   h   pc      fv  epc     mis cnt
        step(1, 1, 0, 64'h0,   0, 64'h0,  0, 64'h0,   0, 64'h0,   0, 0, "reset0");
        step(1, 1, 0, 64'h0,   0, 64'h0,  0, 64'h0,   0, 64'h0,   0, 0, "reset1");
        step(0, 1, 0, 64'h0,   0, 64'h0,  0, 64'h0,   1, 64'h0,   0, 0, "boot_exit");
        step(0, 1, 0, 64'h0,   0, 64'h0,  0, 64'h4,   1, 64'h0,   0, 1, "seq4");
        step(0, 1, 0, 64'h0,   0, 64'h0,  0, 64'h8,   1, 64'h0,   0, 2, "seq8");
        step(0, 0, 0, 64'h0,   0, 64'h0,  0, 64'h8,   1, 64'h0,   0, 2, "stall1");
        step(0, 0, 0, 64'h0,   0, 64'h0,  0, 64'h8,   1, 64'h0,   0, 2, "stall2");
        step(0, 0, 0, 64'h0,   0, 64'h0,  0, 64'h8,   1, 64'h0,   0, 2, "stall3");
        step(0, 1, 0, 64'h0,   0, 64'h0,  0, 64'hC,   1, 64'h0,   0, 3, "seq12");
        step(0, 1, 1, 64'h100, 0, 64'h0,  0, 64'h100, 1, 64'h0,   0, 4, "redirect");
        step(0, 0, 1, 64'h102, 0, 64'h0,  0, 64'h800, 1, 64'h102, 1, 4, "misalign");
        step(0, 0, 0, 64'h0,   0, 64'h0,  0, 64'h800, 1, 64'h102, 0, 4, "misalign_drop");
        step(0, 1, 1, 64'h200, 1, 64'h40, 0, 64'h800, 1, 64'h40,  0, 5, "trap_vs_redir");
        step(0, 0, 1, 64'h202, 1, 64'h44, 0, 64'h800, 1, 64'h44,  0, 5, "trap_vs_misal");
        step(0, 0, 1, 64'h20,  0, 64'h0,  0, 64'h20,  1, 64'h44,  0, 5, "to_0x20");
        step(0, 0, 0, 64'h0,   0, 64'h0,  1, 64'h20,  0, 64'h44,  0, 5, "halt_enter");
        for (int i = 0; i < 4; i++)
            step(0, 1, 0, 64'h0, 0, 64'h0, 1, 64'h20, 0, 64'h44,  0, 5, "halt_hold");
        step(0, 0, 0, 64'h0,   0, 64'h0,  0, 64'h20,  1, 64'h44,  0, 5, "resume");
        step(0, 1, 0, 64'h0,   0, 64'h0,  0, 64'h24,  1, 64'h44,  0, 6, "resume_seq");
        step(0, 1, 0, 64'h0,   0, 64'h0,  1, 64'h28,  0, 64'h44,  0, 7, "halt_accept");
        step(0, 1, 0, 64'h0,   1, 64'h60, 1, 64'h800, 0, 64'h60,  0, 7, "trap_in_halt");
        step(0, 1, 1, 64'h300, 0, 64'h0,  1, 64'h300, 0, 64'h60,  0, 7, "redir_in_halt");
        step(0, 1, 0, 64'h0,   0, 64'h0,  0, 64'h300, 1, 64'h60,  0, 7, "resume2");
        step(1, 1, 0, 64'h0,   0, 64'h0,  0, 64'h0,   0, 64'h0,   0, 0, "mid_reset");
        step(0, 1, 0, 64'h0,   0, 64'h0,  1, 64'h0,   0, 64'h0,   0, 0, "boot_to_halt");
        step(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, 0,
             64'hFFFF_FFFF_FFFF_FFFC, 1, 64'h0, 0, 0, "to_top");
        step(0, 1, 0, 64'h0,   0, 64'h0,  0, 64'h0,   1, 64'h0,   0, 1, "pc_wrap");
        step(0, 0, 0, 64'h0,   0, 64'h0,  0, 64'h0,   1, 64'h0,   0, 1, "post_wrap");

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        #2;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
